uifdma_rd_arb: RTL

Two-client read-channel arbiter that shares one FDMA read engine between two DBUF read controllers: port 0 is the normal-orientation reader, port 1 the rotated reader. It sits between the DBUF read controllers and the FDMA/AXI master in the `I_ui_clk` domain. Each client sees a private FDMA read interface with exactly the handshake semantics of a dedicated engine. Arbitration is per burst, round-robin by default.

---
 rtl/uifdma_arb_pkg.sv | 20 ++
 rtl/uifdma_arb_pick.sv | 42 ++++
 rtl/uifdma_rd_arb.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uifdma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uifdma_arb_pkg
// Description : Shared constants for the two-client FDMA read arbiter.
//               Arbiter FSM state encodings and client index constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uifdma_arb_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] A_IDLE = 2'd0;
  localparam logic [1:0] A_REQ  = 2'd1;
  localparam logic [1:0] A_BUSY = 2'd2;

  // Client indices into request/grant vectors
  localparam int C_NORM = 0;  // normal-orientation reader
  localparam int C_ROT  = 1;  // rotated reader

endpackage
`default_nettype wire

// File: rtl/uifdma_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : uifdma_arb_pick
// Description : Combinational winner selection for the FDMA read arbiter.
//               Produces a one-hot grant from the two request lines.
//               Macro FDMA_ARB_FIXED_PRIO_EN: client 0 always wins a tie and
//               the round-robin pointer is ignored. Default: the pointer
//               chooses the winner when both clients request.
// Ports       : req [1:0] in  - client requests (bit X = client X)
//               ptr       in  - round-robin pointer (client favoured on tie)
//               gnt [1:0] out - one-hot winner, 00 when no request
// Revision    : 1.0 - initial release
// ============================================================================
module uifdma_arb_pick
  import uifdma_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

`ifdef FDMA_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ptr;

  always_comb begin
    gnt         = 2'b00;
    gnt[C_NORM] = req[C_NORM];
    gnt[C_ROT]  = req[C_ROT] & ~req[C_NORM];
  end
`else
  always_comb begin
    gnt = req;
    // Tie: the pointer names the client whose turn it is
    if (req[C_NORM] && req[C_ROT]) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/uifdma_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : uifdma_rd_arb
// Description : Shares one FDMA read engine between two DBUF read
//               controllers (client 0 normal, client 1 rotated). Each
//               client sees a private FDMA read interface; arbitration is
//               per burst. Tie-break policy is selected by the macro
//               FDMA_ARB_FIXED_PRIO_EN (defined: client 0 wins ties;
//               undefined: round-robin).
// Ports       : I_ui_clk / I_ui_rstn        - clock, async active-low reset
//               I_cX_fdma_raddr/rareq/rsize - client X burst command
//               O_cX_fdma_rbusy/rvalid/rdata- client X private status/data
//               O_fdma_raddr/rareq/rsize    - command to the engine
//               I_fdma_rbusy/rvalid/rdata   - engine status and read data
//               O_fdma_rready               - always 1
//               O_arb_gnt                   - one-hot grant, 00 when idle
//               I_cnt_clr                   - sync clear of burst counters
//               O_cX_bcnt                   - completed bursts per client
// Revision    : 1.0 - initial release
// ============================================================================
module uifdma_rd_arb
  import uifdma_arb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      I_ui_clk,
  input  logic                      I_ui_rstn,
  input  logic [AXI_ADDR_WIDTH-1:0] I_c0_fdma_raddr,
  input  logic                      I_c0_fdma_rareq,
  input  logic [15:0]               I_c0_fdma_rsize,
  output logic                      O_c0_fdma_rbusy,
  output logic                      O_c0_fdma_rvalid,
  output logic [AXI_DATA_WIDTH-1:0] O_c0_fdma_rdata,
  input  logic [AXI_ADDR_WIDTH-1:0] I_c1_fdma_raddr,
  input  logic                      I_c1_fdma_rareq,
  input  logic [15:0]               I_c1_fdma_rsize,
  output logic                      O_c1_fdma_rbusy,
  output logic                      O_c1_fdma_rvalid,
  output logic [AXI_DATA_WIDTH-1:0] O_c1_fdma_rdata,
  output logic [AXI_ADDR_WIDTH-1:0] O_fdma_raddr,
  output logic                      O_fdma_rareq,
  output logic [15:0]               O_fdma_rsize,
  input  logic                      I_fdma_rbusy,
  input  logic                      I_fdma_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0] I_fdma_rdata,
  output logic                      O_fdma_rready,
  output logic [1:0]                O_arb_gnt,
  input  logic                      I_cnt_clr,
  output logic [CNT_WIDTH-1:0]      O_c0_bcnt,
  output logic [CNT_WIDTH-1:0]      O_c1_bcnt
);

  logic [1:0]                r_state;
  logic                      r_rareq;
  logic [AXI_ADDR_WIDTH-1:0] r_raddr;
  logic [15:0]               r_rsize;
  logic [1:0]                r_gnt;
  logic                      r_ptr;
  logic [CNT_WIDTH-1:0]      r_c0_bcnt;
  logic [CNT_WIDTH-1:0]      r_c1_bcnt;

  logic [1:0]                w_req;
  logic [1:0]                w_pick;
  logic                      w_done;

  assign w_req  = {I_c1_fdma_rareq, I_c0_fdma_rareq};
  // Burst is finished on the first A_BUSY cycle with the engine idle
  assign w_done = (r_state == A_BUSY) && !I_fdma_rbusy;

  uifdma_arb_pick u_pick (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_pick)
  );

  always_ff @(posedge I_ui_clk or negedge I_ui_rstn) begin
    if (!I_ui_rstn) begin
      r_state <= A_IDLE;
      r_rareq <= 1'b0;
      r_raddr <= '0;
      r_rsize <= '0;
      r_gnt   <= 2'b00;
      r_ptr   <= 1'b0;
    end else begin
      case (r_state)
        A_IDLE: begin
          if (|w_req) begin
            r_gnt   <= w_pick;
            r_rareq <= 1'b1;
            r_raddr <= w_pick[C_ROT] ? I_c1_fdma_raddr : I_c0_fdma_raddr;
            r_rsize <= w_pick[C_ROT] ? I_c1_fdma_rsize : I_c0_fdma_rsize;
            r_state <= A_REQ;
          end
        end
        A_REQ: begin
          // Command is committed; client request lines are not looked at
          if (I_fdma_rbusy) begin
            r_rareq <= 1'b0;
            r_state <= A_BUSY;
          end
        end
        A_BUSY: begin
          if (!I_fdma_rbusy) begin
            // Next tie goes to the client that was not just served
            r_ptr   <= r_gnt[C_NORM];
            r_gnt   <= 2'b00;
            r_state <= A_IDLE;
          end
        end
        default: begin
          r_rareq <= 1'b0;
          r_gnt   <= 2'b00;
          r_state <= A_IDLE;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment; counters wrap naturally
  always_ff @(posedge I_ui_clk or negedge I_ui_rstn) begin
    if (!I_ui_rstn) begin
      r_c0_bcnt <= '0;
      r_c1_bcnt <= '0;
    end else if (I_cnt_clr) begin
      r_c0_bcnt <= '0;
      r_c1_bcnt <= '0;
    end else if (w_done) begin
      if (r_gnt[C_NORM]) r_c0_bcnt <= r_c0_bcnt + 1'b1;
      if (r_gnt[C_ROT])  r_c1_bcnt <= r_c1_bcnt + 1'b1;
    end
  end

  assign O_fdma_raddr     = r_raddr;
  assign O_fdma_rareq     = r_rareq;
  assign O_fdma_rsize     = r_rsize;
  assign O_fdma_rready    = 1'b1;
  assign O_arb_gnt        = r_gnt;
  assign O_c0_bcnt        = r_c0_bcnt;
  assign O_c1_bcnt        = r_c1_bcnt;

  // Private views: only the granted client sees engine busy/valid
  assign O_c0_fdma_rbusy  = r_gnt[C_NORM] & I_fdma_rbusy;
  assign O_c1_fdma_rbusy  = r_gnt[C_ROT]  & I_fdma_rbusy;
  assign O_c0_fdma_rvalid = r_gnt[C_NORM] & I_fdma_rvalid;
  assign O_c1_fdma_rvalid = r_gnt[C_ROT]  & I_fdma_rvalid;
  assign O_c0_fdma_rdata  = I_fdma_rdata;
  assign O_c1_fdma_rdata  = I_fdma_rdata;

endmodule
`default_nettype wire
